cas_key_loader: RTL and testbench

- Serial key-provisioning unit: the write side of the key inputs of a CAS-Lock-protected netlist.
- Receives a key frame (KEY_W key bits plus an 8-bit CRC) over a bit-serial valid/ready link.
- On a good CRC, commits the key to a holding register and drives the locked block's key inputs.
- Keeps a decoy key applied until a good key is committed; enforces a bounded retry count with permanent lockout.

---
 rtl/cas_key_loader.sv | 194 +++++++++++++++++++
 tb/tb_cas_key_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cas_key_loader.sv
// Serial key loader for a CAS-Lock protected netlist: shifts in a key frame with CRC-8,
// commits verified keys to keyinput, keeps a decoy applied otherwise, and locks out after repeated failures.
module cas_key_loader #(
  parameter int               KEY_W     = 64,
  parameter int               MAX_TRIES = 3,
  parameter logic [KEY_W-1:0] DECOY_KEY = '0
) (
  input  logic             GCLK,
  input  logic             GRST_N,
  input  logic             key_sdi,
  input  logic             key_svalid,
  output logic             key_sready,
  input  logic             key_clear,
  output logic [KEY_W-1:0] keyinput,
  output logic             key_valid,
  output logic             key_err,
  output logic             lockout,
  output logic [3:0]       tries
);

  // state      | meaning
  // IDLE       | waiting for the first bit of a frame
  // SHIFT_KEY  | accepting key bits MSB-first, CRC running
  // SHIFT_CRC  | accepting the 8 received CRC bits
  // CHECK      | one-cycle compare of computed vs received CRC
  // LOADED     | verified key applied (first cycle may still be committing)
  // LOCKOUT    | too many CRC failures; only GRST_N exits
  typedef enum logic [2:0] {
    ST_IDLE, ST_SHIFT_KEY, ST_SHIFT_CRC, ST_CHECK, ST_LOADED, ST_LOCKOUT
  } state_e;

  localparam int CW = (KEY_W > 8) ? $clog2(KEY_W) : 3;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] shift_q, shift_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       rx_crc_q, rx_crc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KEY_W-1:0] keyinput_q, keyinput_d;
  logic             key_valid_q, key_valid_d;
  logic             key_err_q, key_err_d;
  logic             lockout_q, lockout_d;
  logic [3:0]       tries_q, tries_d;
  logic             sready_q, sready_d;
  logic             pend_q, pend_d;
  logic             xfer;
  logic [3:0]       tries_inc;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    crc8_step = {c[6:0], 1'b0} ^ (((c[7] ^ b) == 1'b1) ? 8'h07 : 8'h00);
  endfunction

  assign xfer      = key_svalid && sready_q;
  assign tries_inc = (tries_q == 4'd15) ? tries_q : tries_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    crc_d       = crc_q;
    rx_crc_d    = rx_crc_q;
    cnt_d       = cnt_q;
    keyinput_d  = keyinput_q;
    key_valid_d = key_valid_q;
    key_err_d   = 1'b0;
    lockout_d   = lockout_q;
    tries_d     = tries_q;
    pend_d      = pend_q;

    case (state_q)
      // IDLE always holds cnt_q == 0, so it shares the key-shift path
      ST_IDLE, ST_SHIFT_KEY: begin
        if (key_clear) begin
          shift_d  = '0;
          crc_d    = '0;
          rx_crc_d = '0;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else if (xfer) begin
          shift_d = {shift_q[KEY_W-2:0], key_sdi};
          crc_d   = crc8_step(crc_q, key_sdi);
          if (cnt_q == CW'(KEY_W - 1)) begin
            cnt_d   = '0;
            state_d = ST_SHIFT_CRC;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = ST_SHIFT_KEY;
          end
        end
      end

      ST_SHIFT_CRC: begin
        if (key_clear) begin
          shift_d  = '0;
          crc_d    = '0;
          rx_crc_d = '0;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else if (xfer) begin
          rx_crc_d = {rx_crc_q[6:0], key_sdi};
          if (cnt_q == CW'(7)) begin
            cnt_d   = '0;
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ST_CHECK: begin
        crc_d    = '0;
        rx_crc_d = '0;
        if (crc_q == rx_crc_q) begin
          pend_d  = 1'b1;
          state_d = ST_LOADED;
        end else begin
          shift_d   = '0;
          key_err_d = 1'b1;
          tries_d   = tries_inc;
          if (tries_inc == 4'(MAX_TRIES)) begin
            lockout_d = 1'b1;
            state_d   = ST_LOCKOUT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      // Commit happens one cycle after CHECK so the key appears two edges after the last bit
      ST_LOADED: begin
        if (key_clear) begin
          keyinput_d  = DECOY_KEY;
          key_valid_d = 1'b0;
          pend_d      = 1'b0;
          shift_d     = '0;
          state_d     = ST_IDLE;
        end else if (pend_q) begin
          keyinput_d  = shift_q;
          key_valid_d = 1'b1;
          pend_d      = 1'b0;
          shift_d     = '0;
        end
      end

      ST_LOCKOUT: begin
        lockout_d   = 1'b1;
        key_valid_d = 1'b0;
        keyinput_d  = DECOY_KEY;
      end

      default: state_d = ST_IDLE;
    endcase

    sready_d = (state_d == ST_IDLE) || (state_d == ST_SHIFT_KEY) ||
               (state_d == ST_SHIFT_CRC);
  end

  always_ff @(posedge GCLK or negedge GRST_N) begin
    if (!GRST_N) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      crc_q       <= '0;
      rx_crc_q    <= '0;
      cnt_q       <= '0;
      keyinput_q  <= DECOY_KEY;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      lockout_q   <= 1'b0;
      tries_q     <= '0;
      sready_q    <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      crc_q       <= crc_d;
      rx_crc_q    <= rx_crc_d;
      cnt_q       <= cnt_d;
      keyinput_q  <= keyinput_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
      lockout_q   <= lockout_d;
      tries_q     <= tries_d;
      sready_q    <= sready_d;
      pend_q      <= pend_d;
    end
  end

  assign key_sready = sready_q;
  assign keyinput   = keyinput_q;
  assign key_valid  = key_valid_q;
  assign key_err    = key_err_q;
  assign lockout    = lockout_q;
  assign tries      = tries_q;

endmodule

// File: tb/tb_cas_key_loader.sv
// Directed bench for cas_key_loader: good/bad frames, stalls, abort, clear, lockout and async reset.
module tb_cas_key_loader;

  localparam logic [63:0] DECOY = 64'h0;
  localparam logic [63:0] KEY_A = 64'hA5C3_0F1E_7788_9901;

  logic        GCLK, GRST_N, key_sdi, key_svalid, key_sready, key_clear;
  logic [63:0] keyinput;
  logic        key_valid, key_err, lockout;
  logic [3:0]  tries;

  int n_cmp = 0;
  int n_mis = 0;
  int err_cycles = 0;
  int leaks = 0;
  int e0;

  cas_key_loader #(.KEY_W(64), .MAX_TRIES(3), .DECOY_KEY(DECOY)) dut (
    .GCLK(GCLK), .GRST_N(GRST_N), .key_sdi(key_sdi), .key_svalid(key_svalid),
    .key_sready(key_sready), .key_clear(key_clear), .keyinput(keyinput),
    .key_valid(key_valid), .key_err(key_err), .lockout(lockout), .tries(tries)
  );

  initial GCLK = 1'b0;
  always #5 GCLK = ~GCLK;

  always @(negedge GCLK) begin
    if (GRST_N) begin
      if (key_err) err_cycles++;
      if (!key_valid && keyinput !== DECOY) leaks++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8_ref(input logic [63:0] k);
    logic [7:0] c = 8'h00;
    for (int i = 63; i >= 0; i--) begin
      if (c[7] ^ k[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Called at a falling edge; returns at the falling edge after the last accepted bit.
  task automatic send_frame(input logic [63:0] k, input logic [7:0] c, input int nbits,
                            input bit stall, input bit blind);
    logic [71:0] frame;
    int guard;
    frame = {k, c};
    for (int i = 0; i < nbits; i++) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        key_svalid = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge GCLK);
      end
      key_svalid = 1'b1;
      key_sdi    = frame[71-i];
      if (!blind) begin
        guard = 0;
        while (!key_sready && guard < 100) begin
          @(negedge GCLK);
          guard++;
        end
        if (guard >= 100) chk("sready_timeout", {63'd0, key_sready}, 64'd1);
      end
      @(negedge GCLK);
    end
    key_svalid = 1'b0;
    key_sdi    = 1'b0;
  endtask

  task automatic check_load(input string tag, input logic [63:0] k);
    chk({tag, "_v_n0"}, {63'd0, key_valid}, 64'd0);
    @(negedge GCLK);
    chk({tag, "_v_n1"}, {63'd0, key_valid}, 64'd0);
    @(negedge GCLK);
    chk({tag, "_v_n2"}, {63'd0, key_valid}, 64'd1);
    chk({tag, "_key"}, keyinput, k);
  endtask

  task automatic pulse_clear();
    key_clear = 1'b1;
    @(negedge GCLK);
    key_clear = 1'b0;
  endtask

  task automatic reset_pulse();
    GRST_N = 1'b0;
    #3;
    chk("rst_key", keyinput, DECOY);
    chk("rst_valid", {63'd0, key_valid}, 64'd0);
    chk("rst_sready", {63'd0, key_sready}, 64'd0);
    chk("rst_lockout", {63'd0, lockout}, 64'd0);
    chk("rst_tries", {60'd0, tries}, 64'd0);
    @(negedge GCLK);
    GRST_N = 1'b1;
    @(negedge GCLK);
  endtask

  initial begin
    GRST_N = 1'b0; key_sdi = 1'b0; key_svalid = 1'b0; key_clear = 1'b0;
    @(negedge GCLK);
    reset_pulse();
    chk("idle_sready", {63'd0, key_sready}, 64'd1);

    // all-zero key, CRC 0x00
    send_frame(64'h0, 8'h00, 72, 1'b0, 1'b0);
    check_load("zero", 64'h0);
    chk("zero_err", err_cycles, 0);
    chk("zero_tries", {60'd0, tries}, 64'd0);

    // clear in LOADED, then reload a non-zero key
    pulse_clear();
    chk("clr_valid", {63'd0, key_valid}, 64'd0);
    chk("clr_key", keyinput, DECOY);
    chk("clr_sready", {63'd0, key_sready}, 64'd1);
    send_frame(KEY_A, crc8_ref(KEY_A), 72, 1'b0, 1'b0);
    check_load("keya", KEY_A);
    pulse_clear();

    // bad CRC then good frame
    e0 = err_cycles;
    send_frame(64'h0, 8'h01, 72, 1'b0, 1'b0);
    repeat (3) @(negedge GCLK);
    chk("bad_err_pulse", err_cycles - e0, 1);
    chk("bad_tries", {60'd0, tries}, 64'd1);
    chk("bad_key", keyinput, DECOY);
    chk("bad_valid", {63'd0, key_valid}, 64'd0);
    chk("bad_sready", {63'd0, key_sready}, 64'd1);
    send_frame(64'h0, 8'h00, 72, 1'b0, 1'b0);
    check_load("retry", 64'h0);
    chk("retry_tries", {60'd0, tries}, 64'd1);
    pulse_clear();

    // random stalls in both shift phases
    send_frame(KEY_A, crc8_ref(KEY_A), 72, 1'b1, 1'b0);
    check_load("stall", KEY_A);
    pulse_clear();

    // abort after 30 bits, then a full good frame
    send_frame(KEY_A, crc8_ref(KEY_A), 30, 1'b0, 1'b0);
    pulse_clear();
    chk("abort_tries", {60'd0, tries}, 64'd1);
    chk("abort_sready", {63'd0, key_sready}, 64'd1);
    chk("abort_key", keyinput, DECOY);
    send_frame(KEY_A, crc8_ref(KEY_A), 72, 1'b0, 1'b0);
    check_load("after_abort", KEY_A);

    // asynchronous reset while LOADED, mid-cycle
    #2 GRST_N = 1'b0;
    #1;
    chk("arst_key", keyinput, DECOY);
    chk("arst_valid", {63'd0, key_valid}, 64'd0);
    chk("arst_tries", {60'd0, tries}, 64'd0);
    @(negedge GCLK);
    GRST_N = 1'b1;
    @(negedge GCLK);

    // three bad frames force lockout
    e0 = err_cycles;
    for (int f = 0; f < 3; f++) begin
      send_frame(KEY_A, crc8_ref(KEY_A) ^ 8'h80, 72, 1'b0, 1'b0);
      repeat (2) @(negedge GCLK);
    end
    chk("lock_errs", err_cycles - e0, 3);
    chk("lock_tries", {60'd0, tries}, 64'd3);
    chk("lock_flag", {63'd0, lockout}, 64'd1);
    chk("lock_sready", {63'd0, key_sready}, 64'd0);
    send_frame(KEY_A, crc8_ref(KEY_A), 72, 1'b0, 1'b1);
    repeat (3) @(negedge GCLK);
    pulse_clear();
    chk("lock_ign_valid", {63'd0, key_valid}, 64'd0);
    chk("lock_ign_key", keyinput, DECOY);
    chk("lock_ign_flag", {63'd0, lockout}, 64'd1);
    chk("lock_ign_tries", {60'd0, tries}, 64'd3);

    reset_pulse();
    chk("post_lock_flag", {63'd0, lockout}, 64'd0);
    chk("post_lock_tries", {60'd0, tries}, 64'd0);
    chk("post_lock_sready", {63'd0, key_sready}, 64'd1);
    chk("no_leak", leaks, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
